// File: rtl/quad_step_decoder.sv
// quad_step_decoder: synchronized, debounced quadrature decoder emitting up/down/enable/err pulses.
// Define QUAD_FULL_STEP_EN to pulse once per full detent (four sub-steps) instead of per transition.
module quad_step_decoder #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic a_in,
  input  logic b_in,
  output logic up,
  output logic down,
  output logic enable,
  output logic err
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IW = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DEBOUNCE_CYCLES + 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t r_state, w_state_nx;
  logic [1:0] r_sync1, r_sync2, r_stable, r_prev;
  logic [1:0][CW-1:0] r_cnt;
  logic [IW-1:0] r_init_cnt;
  logic w_exit, w_run, w_step, w_cw, w_err, w_up, w_down;
  logic [1:0] w_chg;
  always_ff @(posedge clk) r_state <= reset ? INIT : w_state_nx;
  always_comb begin
    w_exit = r_state == INIT && r_init_cnt == I_LAST;
    w_state_nx = w_exit ? RUN : r_state;
  end
  assign w_run = r_state == RUN;
  // Bit 1 is channel A, bit 0 is channel B throughout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_stable <= '0;
      r_prev <= '0;
      r_cnt <= '0;
      r_init_cnt <= '0;
    end else begin
      r_sync1 <= {a_in, b_in};
      r_sync2 <= r_sync1;
      if (!w_run) begin
        r_init_cnt <= w_exit ? r_init_cnt : r_init_cnt + 1'b1;
        if (w_exit) begin
          r_stable <= r_sync2;
          r_prev <= r_sync2;
        end
      end else begin
        r_prev <= r_stable;
        for (int i = 0; i < 2; i++) begin
          if (r_sync2[i] == r_stable[i]) r_cnt[i] <= '0;
          else if (r_cnt[i] == C_LAST) begin
            r_cnt[i] <= '0;
            r_stable[i] <= r_sync2[i];
          end else if (r_cnt[i] != C_MAX) r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end
  // Gray-code direction: clockwise exactly when old A differs from new B.
  assign w_chg = r_stable ^ r_prev;
  assign w_step = w_run && (^w_chg);
  assign w_err = w_run && (&w_chg);
  assign w_cw = r_prev[1] ^ r_stable[0];
`ifdef QUAD_FULL_STEP_EN
  logic [2:0] r_acc;
  logic [3:0] w_sum;
  assign w_sum = {r_acc[2], r_acc} + (w_cw ? 4'b0001 : 4'b1111);
  assign w_up = w_step && w_sum == 4'b0100;
  assign w_down = w_step && w_sum == 4'b1100;
  always_ff @(posedge clk) begin
    if (reset || w_err) r_acc <= '0;
    else if (w_step) r_acc <= (w_up || w_down) ? 3'b000 : w_sum[2:0];
  end
`else
  assign w_up = w_step && w_cw;
  assign w_down = w_step && !w_cw;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      up <= 1'b0;
      down <= 1'b0;
      enable <= 1'b0;
      err <= 1'b0;
    end else begin
      up <= w_up;
      down <= w_down;
      enable <= w_up || w_down;
      err <= w_err;
    end
  end
endmodule
